cpu_csr_axi_master: RTL and testbench

Bridge from the CPU's simple load/store request port to a single-beat AXI4 master that drives the `cpu_csr` register-file slave. It sits directly upstream of `cpu_csr`.

- Each accepted CPU request becomes exactly one AXI4 transaction: INCR burst, length 0, 4-byte size.
- Each transaction returns exactly one response pulse to the CPU.
- AXI errors, ID mismatches, missing `rlast` and a slave that never answers are all reported as errors.

---
 rtl/cpu_csr_pkg.sv | 18 +
 rtl/cpu_csr_axi_master_if.sv | 74 +++++++
 rtl/cpu_csr_axi_master.sv | 219 +++++++++++++++++++++
 tb/tb_cpu_csr_axi_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_csr_pkg.sv
// Shared types and AXI constants for the CPU-to-CSR AXI4 bridge.
package cpu_csr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_DRAIN
  } csr_mst_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         CSR_NUM_REGS   = 32;

endpackage

// File: rtl/cpu_csr_axi_master_if.sv
// CPU request/response port plus single-beat AXI4 master channels.
interface cpu_csr_axi_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [1:0]  m_axi_awburst;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [3:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [3:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [1:0]  m_axi_arburst;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [3:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_axi_awid, m_axi_awaddr, m_axi_awburst, m_axi_awlen, m_axi_awsize, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arburst, m_axi_arlen, m_axi_arsize, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_axi_awid, m_axi_awaddr, m_axi_awburst, m_axi_awlen, m_axi_awsize, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arburst, m_axi_arlen, m_axi_arsize, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/cpu_csr_axi_master.sv
// Turns each CPU load/store into one single-beat AXI4 transaction with
// exactly one response pulse; errors, ID/rlast mismatches and timeouts flagged.
module cpu_csr_axi_master
  import cpu_csr_pkg::*;
#(
  parameter logic [3:0]  AXI_ID  = 4'd1,
  parameter int unsigned TIMEOUT = 256
) (
  input logic                  s_aclk,
  input logic                  s_areset,
  cpu_csr_axi_master_if.master bus
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  csr_mst_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic        bready_q, bready_d, rready_q, rready_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        timeout;

  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    // Address-phase valids drop on their own handshake in any state, DRAIN included.
    if (awvalid_q && bus.m_axi_awready) begin
      awvalid_d = 1'b0;
      aw_done_d = 1'b1;
    end
    if (wvalid_q && bus.m_axi_wready) begin
      wvalid_d = 1'b0;
      w_done_d = 1'b1;
    end
    if (arvalid_q && bus.m_axi_arready) arvalid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[31:2];
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          if (bus.req_addr[1:0] != 2'b00) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (bus.req_we) begin
            state_d   = ST_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WADDR: begin
        if (aw_done_d && w_done_d) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end else if (timeout) begin
          state_d     = ST_DRAIN;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_WRESP: begin
        if (bus.m_axi_bvalid) begin
          state_d     = ST_IDLE;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (bus.m_axi_bresp != AXI_RESP_OKAY) || (bus.m_axi_bid != AXI_ID);
        end else if (timeout) begin
          state_d     = ST_DRAIN;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_RADDR: begin
        if (bus.m_axi_arready) begin
          state_d  = ST_RDATA;
          rready_d = 1'b1;
        end else if (timeout) begin
          state_d     = ST_DRAIN;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_RDATA: begin
        if (bus.m_axi_rvalid) begin
          state_d     = ST_IDLE;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.m_axi_rdata;
          rsp_err_d   = (bus.m_axi_rresp != AXI_RESP_OKAY) || (bus.m_axi_rid != AXI_ID)
                        || !bus.m_axi_rlast;
        end else if (timeout) begin
          state_d     = ST_DRAIN;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        // The transaction still owes the slave a response handshake; absorb it silently.
        if (we_q) begin
          if (aw_done_d && w_done_d) begin
            if (!bready_q) begin
              bready_d = 1'b1;
            end else if (bus.m_axi_bvalid) begin
              bready_d = 1'b0;
              state_d  = ST_IDLE;
            end
          end
        end else if (arvalid_q) begin
          if (bus.m_axi_arready) rready_d = 1'b1;
        end else if (rready_q && bus.m_axi_rvalid) begin
          rready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {ST_WADDR, ST_WRESP, ST_RADDR, ST_RDATA}) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE) && !s_areset;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_rdata     = rsp_rdata_q;

  assign bus.m_axi_awid    = AXI_ID;
  assign bus.m_axi_awaddr  = {addr_q, 2'b00};
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = AXI_SIZE_4B;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = wstrb_q;
  assign bus.m_axi_wlast   = 1'b1;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;
  assign bus.m_axi_arid    = AXI_ID;
  assign bus.m_axi_araddr  = {addr_q, 2'b00};
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = AXI_SIZE_4B;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_cpu_csr_axi_master.sv
// Bench for cpu_csr_axi_master: vector table + AXI slave model + response scoreboard.
module tb_cpu_csr_axi_master;
  import cpu_csr_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cpu_csr_axi_master_if bus();

  cpu_csr_axi_master #(.AXI_ID(4'd1), .TIMEOUT(8)) dut (
    .s_aclk   (clk),
    .s_areset (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_stall;
    int          w_stall;
    int          ar_stall;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic [3:0]  rid;
    logic        rlast;
    bit          b_never;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] mem [CSR_NUM_REGS];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int aw_stall, input int w_stall,
                              input int ar_stall, input logic [1:0] bresp, input logic [3:0] bid,
                              input logic [3:0] rid, input logic rlast, input bit b_never,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.aw_stall = aw_stall; v.w_stall = w_stall; v.ar_stall = ar_stall;
    v.bresp = bresp; v.bid = bid; v.rid = rid; v.rlast = rlast; v.b_never = b_never;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_slave();
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
  endtask

  // Drives one request, plays the AXI slave until the response arrives.
  task automatic do_txn(input vec_t v);
    int k = 1;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    bit aw_done = 0, w_done = 0, ar_done = 0, b_sent = 0, r_sent = 0;
    bit got_rsp = 0, bus_seen = 0, mem_wr = 0;
    logic [31:0] aw_addr0 = '0, ar_addr0 = '0, wa = '0, ra = '0, wd = '0;
    logic [3:0]  ws = '0;
    exp_t e;
    @(negedge clk);
    check("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wstrb = v.strb;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!got_rsp && k < 60) begin
      clear_slave();
      if (bus.rsp_valid) begin
        got_rsp = 1;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, e.rdata});
          check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e.err});
          check("rsp_latency", 64'(k), 64'(e.lat));
        end
      end
      if (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_arvalid) bus_seen = 1;
      if (v.we && aw_done) begin
        check("awvalid_drop", {63'd0, bus.m_axi_awvalid}, 64'd0);
      end else if (bus.m_axi_awvalid) begin
        if (aw_cnt == 0) begin
          aw_addr0 = bus.m_axi_awaddr;
          check("awaddr", {32'd0, bus.m_axi_awaddr}, {32'd0, v.addr[31:2], 2'b00});
          check("aw_len_size_burst_id",
                {49'd0, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awid},
                {49'd0, 8'd0, 3'd2, 2'b01, 4'd1});
        end else begin
          check("awaddr_stable", {32'd0, bus.m_axi_awaddr}, {32'd0, aw_addr0});
        end
        if (aw_cnt == v.aw_stall) begin
          bus.m_axi_awready = 1'b1;
          aw_done = 1;
          wa = bus.m_axi_awaddr;
        end
        aw_cnt++;
      end
      if (v.we && w_done) begin
        check("wvalid_drop", {63'd0, bus.m_axi_wvalid}, 64'd0);
      end else if (bus.m_axi_wvalid) begin
        if (w_cnt == 0)
          check("w_data_strb_last", {27'd0, bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast},
                {27'd0, v.wdata, v.strb, 1'b1});
        if (w_cnt == v.w_stall) begin
          bus.m_axi_wready = 1'b1;
          w_done = 1;
          wd = bus.m_axi_wdata;
          ws = bus.m_axi_wstrb;
        end
        w_cnt++;
      end
      if (aw_done && w_done && !mem_wr) begin
        mem_wr = 1;
        for (int b = 0; b < 4; b++)
          if (ws[b]) mem[wa[6:2]][b*8 +: 8] = wd[b*8 +: 8];
      end
      if (bus.m_axi_bready && aw_done && w_done && !b_sent && !v.b_never) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bid    = v.bid;
        bus.m_axi_bresp  = v.bresp;
        b_sent = 1;
      end
      if (!v.we && ar_done) begin
        check("arvalid_drop", {63'd0, bus.m_axi_arvalid}, 64'd0);
      end else if (bus.m_axi_arvalid) begin
        if (ar_cnt == 0) begin
          ar_addr0 = bus.m_axi_araddr;
          check("araddr", {32'd0, bus.m_axi_araddr}, {32'd0, v.addr[31:2], 2'b00});
          check("ar_len_size_burst_id",
                {49'd0, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arid},
                {49'd0, 8'd0, 3'd2, 2'b01, 4'd1});
        end else begin
          check("araddr_stable", {32'd0, bus.m_axi_araddr}, {32'd0, ar_addr0});
        end
        if (ar_cnt == v.ar_stall) begin
          bus.m_axi_arready = 1'b1;
          ar_done = 1;
          ra = bus.m_axi_araddr;
        end
        ar_cnt++;
      end
      if (bus.m_axi_rready && ar_done && !r_sent) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = mem[ra[6:2]];
        bus.m_axi_rid    = v.rid;
        bus.m_axi_rresp  = 2'b00;
        bus.m_axi_rlast  = v.rlast;
        r_sent = 1;
      end
      if (!got_rsp) begin
        k++;
        @(negedge clk);
      end
    end
    if (!got_rsp) begin
      check("rsp_timeout", 64'd0, 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (v.addr[1:0] != 2'b00) check("no_bus_traffic", {63'd0, bus_seen}, 64'd0);
    if (!v.b_never) begin
      repeat (2) begin
        @(negedge clk);
        check("single_rsp", {63'd0, bus.rsp_valid}, 64'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < CSR_NUM_REGS; i++) mem[i] = '0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wstrb = '0;
    clear_slave();
    bus.m_axi_bid = '0; bus.m_axi_bresp = '0;
    bus.m_axi_rid = '0; bus.m_axi_rdata = '0; bus.m_axi_rresp = '0; bus.m_axi_rlast = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_handshakes",
          {59'd0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
           bus.m_axi_arvalid, bus.m_axi_rready}, 64'd0);
    check("reset_rsp", {30'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 64'd0);
    check("reset_req_ready", {63'd0, bus.req_ready}, 64'd0);
    rst = 1'b0;

    //            we    addr           wdata          strb    aw w ar bresp  bid   rid   rl bn exp_rdata      err lat
    vecs.push_back(mk(1, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0,         0, 3));
    vecs.push_back(mk(0, 32'h0000_0014, 32'h0,         4'h0,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'hDEAD_BEEF, 0, 3));
    vecs.push_back(mk(1, 32'h0000_003C, 32'h0000_BEEF, 4'b0011,0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0,         0, 3));
    vecs.push_back(mk(1, 32'h0000_0000, 32'h1234_5678, 4'hF,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0,         0, 3));
    vecs.push_back(mk(1, 32'h0000_007C, 32'hCAFE_BABE, 4'hF,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0,         0, 3));
    vecs.push_back(mk(0, 32'h0000_0000, 32'h0,         4'h0,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h1234_5678, 0, 3));
    vecs.push_back(mk(0, 32'h0000_007C, 32'h0,         4'h0,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'hCAFE_BABE, 0, 3));
    vecs.push_back(mk(0, 32'h0000_003C, 32'h0,         4'h0,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0000_BEEF, 0, 3));
    vecs.push_back(mk(1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF,   5, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0,         0, 8));
    vecs.push_back(mk(0, 32'h0000_0020, 32'h0,         4'h0,   0, 0, 5, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0BAD_F00D, 0, 8));
    vecs.push_back(mk(1, 32'h0000_002C, 32'h5555_AAAA, 4'hF,   0, 3, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0,         0, 6));
    vecs.push_back(mk(1, 32'h0000_0024, 32'h1111_2222, 4'hF,   0, 0, 0, 2'b10, 4'd1, 4'd1, 1, 0, 32'h0,         1, 3));
    vecs.push_back(mk(1, 32'h0000_0030, 32'h3333_4444, 4'hF,   0, 0, 0, 2'b00, 4'd3, 4'd1, 1, 0, 32'h0,         1, 3));
    vecs.push_back(mk(0, 32'h0000_0014, 32'h0,         4'h0,   0, 0, 0, 2'b00, 4'd1, 4'd7, 1, 0, 32'hDEAD_BEEF, 1, 3));
    vecs.push_back(mk(0, 32'h0000_0014, 32'h0,         4'h0,   0, 0, 0, 2'b00, 4'd1, 4'd1, 0, 0, 32'hDEAD_BEEF, 1, 3));
    vecs.push_back(mk(1, 32'h0000_0015, 32'hFFFF_FFFF, 4'hF,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0,         1, 1));
    vecs.push_back(mk(0, 32'h0000_0015, 32'h0,         4'h0,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'h0,         1, 1));
    vecs.push_back(mk(0, 32'h0000_0014, 32'h0,         4'h0,   0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0, 32'hDEAD_BEEF, 0, 3));

    foreach (vecs[i]) do_txn(vecs[i]);

    // Write timeout: WRESP entered at T+2, never answered, so the error lands at T+10.
    do_txn(mk(1, 32'h0000_0028, 32'h7777_8888, 4'hF, 0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 1,
              32'h0, 1, 10));
    check("drain_bready_held", {63'd0, bus.m_axi_bready}, 64'd1);
    check("drain_not_ready", {63'd0, bus.req_ready}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("drain_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bid    = 4'd1;
    bus.m_axi_bresp  = 2'b00;
    @(negedge clk);
    bus.m_axi_bvalid = 1'b0;
    check("late_b_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    check("drain_released_bready", {63'd0, bus.m_axi_bready}, 64'd0);
    check("drain_back_idle", {63'd0, bus.req_ready}, 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("late_b_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end

    // Reset while waiting in RDATA.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h14;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_seq_arvalid", {63'd0, bus.m_axi_arvalid}, 64'd1);
    bus.m_axi_arready = 1'b1;
    @(negedge clk);
    bus.m_axi_arready = 1'b0;
    check("rst_seq_rready", {63'd0, bus.m_axi_rready}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_handshakes",
          {59'd0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
           bus.m_axi_arvalid, bus.m_axi_rready}, 64'd0);
    check("rst_async_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_async_req_ready", {63'd0, bus.req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end
    do_txn(mk(0, 32'h0000_0014, 32'h0, 4'h0, 0, 0, 0, 2'b00, 4'd1, 4'd1, 1, 0,
              32'hDEAD_BEEF, 0, 3));

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
